threat_range_classifier: RTL and testbench
==========================================

Name: threat_range_classifier

Overview:
- Sits directly downstream of coord_parser and consumes its x/y/z coordinate triple through a valid/ready handshake.
- Computes squared slant range r² = x² + y² + z² with a sequential one-square-per-cycle datapath.
- Classifies the target as IGNORE, TRACK or ENGAGE against range and altitude thresholds.
- Presents the result to the fire-control stage over a second valid/ready handshake.

Parameters:
- ENGAGE_R2, 34'd1_000_000: inclusive squared-range limit for ENGAGE (radius 1000 units).
- TRACK_R2, 34'd25_000_000: inclusive squared-range limit for TRACK (radius 5000 units).
- MIN_ALT, 16'd50: a z below this value is ground clutter and always classified IGNORE.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- x_coord  input  16  unsigned X from coord_parser.
- y_coord  input  16  unsigned Y from coord_parser.
- z_coord  input  16  unsigned Z (altitude) from coord_parser.
- data_valid  input  1  coordinate triple valid.
- data_ready  output  1  block can accept a triple; drives coord_parser's data_ready.
- range_sq  output  34  registered r² of the current result.
- threat_class  output  2  00 IGNORE, 01 TRACK, 10 ENGAGE; 11 is never driven.
- threat_valid  output  1  result valid.
- threat_ready  input  1  downstream accepts the result.
- engage_count  output  8  saturating count of ENGAGE results delivered.

Behaviour:
- Reset (asynchronous, any state): state to IDLE; data_ready=1; threat_valid=0; range_sq=0; threat_class=00; engage_count=0; internal accumulator and coordinate latches cleared.
- States: IDLE, SQ_X, SQ_Y, SQ_Z, OUT. data_ready is registered and is 1 only in IDLE.
- IDLE: an accept occurs on the edge where data_valid && data_ready (edge E0). At E0, latch x/y/z, clear the accumulator, go to SQ_X. Without data_valid, stay in IDLE.
- SQ_X (edge E1): acc <= x². Go to SQ_Y.
- SQ_Y (edge E2): acc <= acc + y². Go to SQ_Z.
- SQ_Z (edge E3): compute r = acc + z².
  - range_sq <= r.
  - threat_class <= classify(r, z).
  - threat_valid <= 1.
  - Go to OUT.
- Latency: threat_valid rises 3 edges after the accept edge.
- Classification (evaluated in order, boundaries inclusive):
  - z < MIN_ALT → IGNORE.
  - else r <= ENGAGE_R2 → ENGAGE.
  - else r <= TRACK_R2 → TRACK.
  - else IGNORE.
- Arithmetic widths:
  - Each square is an unsigned 16x16 → 32-bit product, zero-extended to 34 bits.
  - The sum is 34 bits. The maximum 3·65535² = 12,884,508,675 fits in 34 bits, so no overflow or saturation logic is needed.
- OUT:
  - range_sq, threat_class and threat_valid hold stable while threat_ready=0, indefinitely.
  - On the edge where threat_ready=1: threat_valid <= 0, go to IDLE; data_ready is 1 from that edge.
  - On that same edge, if threat_class is ENGAGE and engage_count < 255, increment engage_count; at 255 it holds.
- Throughput: at most one triple per 5 cycles. No acceptance is possible while a result is pending.
- data_valid behaviour outside IDLE: changes to data_valid or the coordinate inputs in non-IDLE states are ignored; latched values are used throughout.
- threat_ready behaviour outside OUT: threat_ready asserted in any state other than OUT has no effect.
- Reset mid-computation or mid-OUT: result is discarded, outputs return to reset values immediately, engage_count is cleared.

Test Plan:
- Altitude rejection: reset, send (10,20,30) → threat_valid 3 edges after accept, range_sq=1400, threat_class=00 (z=30 < 50).
- ENGAGE and boundary band:
  - Send (100,200,300) → range_sq=140000, class=10; after handshake engage_count=1.
  - Send (0,0,1000) → range_sq=1,000,000, class=10 (inclusive boundary).
  - Send (0,0,1001) → 1,002,001, class=01.
- Width and TRACK edge:
  - Send (65535,65535,65535) → range_sq=12,884,508,675 (0x2FFFA0003), class=00.
  - Send (3000,4000,50) → 25,002,500 → class=00.
  - Send (3000,3999,50) → 24,994,501 → class=01.
- Backpressure: hold threat_ready=0 for 10 cycles after threat_valid → range_sq and class stable, data_ready=0, changing inputs with data_valid=1 are not accepted. Raise threat_ready → threat_valid falls next edge, data_ready=1.
- Reset mid-operation: assert reset_n=0 asynchronously in SQ_Y → threat_valid=0, data_ready=1, range_sq=0 immediately; the next triple (100,200,300) completes normally.
- Counter saturation: deliver 260 ENGAGE results (100,200,300) → engage_count reaches 255 and holds; a further ENGAGE leaves it at 255.

Source files
------------

// File: rtl/threat_range_classifier.sv
// ---------------------------------------------------------------------------
// threat_range_classifier
//
// Purpose:
//   Accepts an unsigned x/y/z coordinate triple from coord_parser.
//   Computes the squared slant range r^2 = x^2 + y^2 + z^2.
//   A single 16x16 multiplier is reused over three cycles, one square per cycle.
//   Classifies the target as IGNORE / TRACK / ENGAGE and hands the result to
//   fire control over a valid/ready handshake.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   x_coord       unsigned X coordinate (16 bit)
//   y_coord       unsigned Y coordinate (16 bit)
//   z_coord       unsigned Z / altitude (16 bit)
//   data_valid    coordinate triple valid
//   data_ready    block can accept a triple (registered, high only in IDLE)
//   range_sq      registered r^2 of the current result (34 bit)
//   threat_class  00 IGNORE, 01 TRACK, 10 ENGAGE
//   threat_valid  result valid
//   threat_ready  downstream accepts the result
//   engage_count  saturating count of ENGAGE results delivered
// ---------------------------------------------------------------------------
module threat_range_classifier #(
    parameter logic [33:0] ENGAGE_R2 = 34'd1_000_000,
    parameter logic [33:0] TRACK_R2  = 34'd25_000_000,
    parameter logic [15:0] MIN_ALT   = 16'd50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] x_coord,
    input  logic [15:0] y_coord,
    input  logic [15:0] z_coord,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [33:0] range_sq,
    output logic [1:0]  threat_class,
    output logic        threat_valid,
    input  logic        threat_ready,
    output logic [7:0]  engage_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ_X = 3'd1,
        SQ_Y = 3'd2,
        SQ_Z = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [1:0] CLASS_IGNORE = 2'b00;
    localparam logic [1:0] CLASS_TRACK  = 2'b01;
    localparam logic [1:0] CLASS_ENGAGE = 2'b10;

    state_t      state_reg;
    state_t      state_next;

    logic [15:0] x_reg;
    logic [15:0] y_reg;
    logic [15:0] z_reg;
    logic [33:0] acc_reg;
    logic [33:0] range_sq_reg;
    logic [1:0]  class_reg;
    logic        valid_reg;
    logic        ready_reg;
    logic [7:0]  engage_count_reg;

    logic [15:0] sq_operand;
    logic [31:0] sq_product;
    logic [33:0] sq_ext;
    logic [33:0] sum_next;
    logic [1:0]  class_next;
    logic        accept;
    logic        deliver;

    // Handshake qualifiers. ready_reg is only high in IDLE.
    // valid_reg is only high in OUT.
    // Inputs seen in any other state therefore fall through untouched.
    assign accept  = data_valid && ready_reg;
    assign deliver = valid_reg && threat_ready;

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)  state_next = SQ_X;
            SQ_X:    state_next = SQ_Y;
            SQ_Y:    state_next = SQ_Z;
            SQ_Z:    state_next = OUT;
            OUT:     if (deliver) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared squarer: the operand is selected by which square is due this cycle.
    always_comb begin
        sq_operand = x_reg;
        case (state_reg)
            SQ_Y:    sq_operand = y_reg;
            SQ_Z:    sq_operand = z_reg;
            default: sq_operand = x_reg;
        endcase
    end

    assign sq_product = {16'd0, sq_operand} * {16'd0, sq_operand};
    assign sq_ext     = {2'b00, sq_product};
    // 3 * 65535^2 < 2^34, so this sum can never wrap.
    assign sum_next   = acc_reg + sq_ext;

    // Classification of the final sum. Thresholds are inclusive.
    // Low altitude overrides range.
    always_comb begin
        class_next = CLASS_IGNORE;
        if (z_reg < MIN_ALT) begin
            class_next = CLASS_IGNORE;
        end else if (sum_next <= ENGAGE_R2) begin
            class_next = CLASS_ENGAGE;
        end else if (sum_next <= TRACK_R2) begin
            class_next = CLASS_TRACK;
        end else begin
            class_next = CLASS_IGNORE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            x_reg            <= 16'd0;
            y_reg            <= 16'd0;
            z_reg            <= 16'd0;
            acc_reg          <= 34'd0;
            range_sq_reg     <= 34'd0;
            class_reg        <= CLASS_IGNORE;
            valid_reg        <= 1'b0;
            ready_reg        <= 1'b1;
            engage_count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == IDLE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        x_reg   <= x_coord;
                        y_reg   <= y_coord;
                        z_reg   <= z_coord;
                        acc_reg <= 34'd0;
                    end
                end
                SQ_X: acc_reg <= sq_ext;
                SQ_Y: acc_reg <= sum_next;
                SQ_Z: begin
                    range_sq_reg <= sum_next;
                    class_reg    <= class_next;
                    valid_reg    <= 1'b1;
                end
                OUT: begin
                    if (deliver) begin
                        valid_reg <= 1'b0;
                        if (class_reg == CLASS_ENGAGE && engage_count_reg != 8'hFF) begin
                            engage_count_reg <= engage_count_reg + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_ready   = ready_reg;
    assign range_sq     = range_sq_reg;
    assign threat_class = class_reg;
    assign threat_valid = valid_reg;
    assign engage_count = engage_count_reg;

endmodule

// File: tb/tb_threat_range_classifier.sv
// ---------------------------------------------------------------------------
// tb_threat_range_classifier
//
// Directed testbench for threat_range_classifier.
// Expected values are hand-computed constants.
// A small saturating counter model predicts engage_count.
// ---------------------------------------------------------------------------
module tb_threat_range_classifier;

    logic        clk;
    logic        reset_n;
    logic [15:0] x_coord;
    logic [15:0] y_coord;
    logic [15:0] z_coord;
    logic        data_valid;
    logic        data_ready;
    logic [33:0] range_sq;
    logic [1:0]  threat_class;
    logic        threat_valid;
    logic        threat_ready;
    logic [7:0]  engage_count;

    int checks;
    int errors;
    int exp_engage;

    threat_range_classifier dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .x_coord      (x_coord),
        .y_coord      (y_coord),
        .z_coord      (z_coord),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .range_sq     (range_sq),
        .threat_class (threat_class),
        .threat_valid (threat_valid),
        .threat_ready (threat_ready),
        .engage_count (engage_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sends one triple through the block and completes the output handshake.
    // With full=1, latency, result, busy and post-handshake state are all checked.
    // With full=0, only threat_valid at the expected edge is checked.
    task automatic send_triple(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                               input logic [33:0] exp_r, input logic [1:0] exp_c, input bit full);
        int budget;
        @(negedge clk);
        x_coord    = x;
        y_coord    = y;
        z_coord    = z;
        data_valid = 1'b1;
        budget     = 0;
        while (!data_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!data_ready) check("ready_timeout", 64'(data_ready), 64'd1);
        @(negedge clk);                      // after accept edge E0
        data_valid = 1'b0;
        if (full) check("busy_after_accept", 64'(data_ready), 64'd0);
        @(negedge clk);                      // after E1
        @(negedge clk);                      // after E2
        if (full) check("valid_early", 64'(threat_valid), 64'd0);
        @(negedge clk);                      // after E3
        check("valid_latency", 64'(threat_valid), 64'd1);
        if (full) begin
            check("range_sq", 64'(range_sq), 64'(exp_r));
            check("class", 64'(threat_class), 64'(exp_c));
        end
        threat_ready = 1'b1;
        @(negedge clk);                      // after handshake edge
        threat_ready = 1'b0;
        if (exp_c == 2'b10 && exp_engage < 255) exp_engage++;
        if (full) begin
            check("valid_drop", 64'(threat_valid), 64'd0);
            check("ready_back", 64'(data_ready), 64'd1);
            check("engage_count", 64'(engage_count), 64'(exp_engage));
        end
        $display("triple (%0d,%0d,%0d) r2=%0d class=%0d engage_count=%0d",
                 x, y, z, range_sq, threat_class, engage_count);
    endtask

    initial begin
        logic [33:0] held_r;
        logic [1:0]  held_c;
        checks       = 0;
        errors       = 0;
        exp_engage   = 0;
        reset_n      = 1'b0;
        x_coord      = 16'd0;
        y_coord      = 16'd0;
        z_coord      = 16'd0;
        data_valid   = 1'b0;
        threat_ready = 1'b0;

        #12;
        check("rst_ready", 64'(data_ready), 64'd1);
        check("rst_valid", 64'(threat_valid), 64'd0);
        check("rst_range", 64'(range_sq), 64'd0);
        check("rst_class", 64'(threat_class), 64'd0);
        check("rst_count", 64'(engage_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Altitude rejection, ENGAGE and range band boundaries
        send_triple(16'd10,    16'd20,    16'd30,   34'd1400,         2'b00, 1'b1);
        send_triple(16'd100,   16'd200,   16'd300,  34'd140000,       2'b10, 1'b1);
        send_triple(16'd0,     16'd0,     16'd1000, 34'd1000000,      2'b10, 1'b1);
        send_triple(16'd0,     16'd0,     16'd1001, 34'd1002001,      2'b01, 1'b1);
        send_triple(16'd65535, 16'd65535, 16'd65535, 34'h2FFFA0003,   2'b00, 1'b1);
        send_triple(16'd3000,  16'd4000,  16'd50,   34'd25002500,     2'b00, 1'b1);
        send_triple(16'd3000,  16'd3999,  16'd50,   34'd24994501,     2'b01, 1'b1);
        send_triple(16'd0,     16'd0,     16'd49,   34'd2401,         2'b00, 1'b1);
        send_triple(16'd0,     16'd0,     16'd50,   34'd2500,         2'b10, 1'b1);

        // Backpressure: hold the result while new triples are offered.
        @(negedge clk);
        x_coord = 16'd3000; y_coord = 16'd3999; z_coord = 16'd50; data_valid = 1'b1;
        @(negedge clk);                      // accepted at E0
        for (int i = 0; i < 3; i++) begin
            x_coord = 16'(i + 1); y_coord = 16'(i + 7); z_coord = 16'(i + 60);
            @(negedge clk);
        end
        held_r = 34'd24994501;
        held_c = 2'b01;
        check("bp_valid_up", 64'(threat_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            x_coord = 16'(i * 37); y_coord = 16'(i * 11); z_coord = 16'(i + 100);
            @(negedge clk);
            check("bp_range", 64'(range_sq), 64'(held_r));
            check("bp_class", 64'(threat_class), 64'(held_c));
            check("bp_valid", 64'(threat_valid), 64'd1);
            check("bp_ready", 64'(data_ready), 64'd0);
        end
        data_valid   = 1'b0;
        threat_ready = 1'b1;
        @(negedge clk);
        threat_ready = 1'b0;
        check("bp_release_valid", 64'(threat_valid), 64'd0);
        check("bp_release_ready", 64'(data_ready), 64'd1);
        $display("backpressure hold 10 cycles r2=%0d class=%0d", held_r, held_c);

        // Asynchronous reset while the block is in SQ_Y
        @(negedge clk);
        x_coord = 16'd500; y_coord = 16'd500; z_coord = 16'd500; data_valid = 1'b1;
        @(negedge clk);                      // after E0, in SQ_X
        data_valid = 1'b0;
        @(negedge clk);                      // after E1, in SQ_Y
        #2 reset_n = 1'b0;
        #1;
        exp_engage = 0;
        check("mid_rst_valid", 64'(threat_valid), 64'd0);
        check("mid_rst_ready", 64'(data_ready), 64'd1);
        check("mid_rst_range", 64'(range_sq), 64'd0);
        check("mid_rst_count", 64'(engage_count), 64'd0);
        $display("async reset in SQ_Y r2=%0d ready=%0d", range_sq, data_ready);
        @(negedge clk);
        reset_n = 1'b1;
        send_triple(16'd100, 16'd200, 16'd300, 34'd140000, 2'b10, 1'b1);

        // Counter saturation
        for (int i = 0; i < 259; i++) begin
            send_triple(16'd100, 16'd200, 16'd300, 34'd140000, 2'b10, 1'b0);
        end
        check("sat_count", 64'(engage_count), 64'd255);
        send_triple(16'd100, 16'd200, 16'd300, 34'd140000, 2'b10, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
